// File: rtl/mdr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mdr_bridge
// Purpose  : Memory data register bridging the internal bus (ib) to a narrower
//            external bus (eb). Internal loads and drives complete in one cycle.
//            External transfers take IB_W/EB_W beats, least significant lane
//            first, each beat using a 4-phase eb_req/eb_ack handshake.
// Options  : MDR_TIMEOUT_EN - aborts a handshake that stalls for TIMEOUT cycles
//            and raises the sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
module mdr_bridge #(
  parameter  int IB_W    = 16,
  parameter  int EB_W    = 8,
  parameter  int TIMEOUT = 15,
  localparam int BEATS   = IB_W / EB_W,
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  inout  wire  [IB_W-1:0] ib,
  input  logic            ib_load,
  input  logic            ib_drive,
  input  logic            start_rd,
  input  logic            start_wr,
  output logic            busy,
  output logic            done,
  output logic            err,
  inout  wire  [EB_W-1:0] eb,
  output logic            eb_req,
  input  logic            eb_ack,
  output logic [BW-1:0]   eb_beat
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IB_W-1:0]   mdr_q, mdr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [EB_W-1:0]   lane_wr;
  logic              tmo_hit;

`ifdef MDR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // The wait counter fires on the last allowed cycle of a stalled phase.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  // Count cycles spent waiting in REQ/REL; restart whenever the state changes.
  always_comb begin
    tmo_d = '0;
    if ((state_q == ST_REQ || state_q == ST_REL) && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // Without the timeout option the handshake waits forever.
  assign tmo_hit = 1'b0;
`endif

  // Select the MDR lane addressed by the current beat for write-out.
  always_comb begin
    lane_wr = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_q == BW'(i)) begin
        lane_wr = mdr_q[i*EB_W +: EB_W];
      end
    end
  end

  // Handshake sequencing, MDR updates and lane capture.
  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    beat_d  = beat_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rd || start_wr) begin
          // Read has priority when both starts arrive together.
          state_d = ST_REQ;
          beat_d  = '0;
          err_d   = 1'b0;
          wr_d    = ~start_rd;
        end else if (ib_load) begin
          mdr_d = ib;
        end
      end
      ST_REQ: begin
        if (eb_ack) begin
          if (!wr_q) begin
            for (int i = 0; i < BEATS; i++) begin
              if (beat_q == BW'(i)) begin
                mdr_d[i*EB_W +: EB_W] = eb;
              end
            end
          end
          state_d = ST_REL;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_REL: begin
        if (!eb_ack) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = ST_REQ;
          end
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Request is registered so it is high exactly while the FSM sits in REQ.
    req_d = (state_d == ST_REQ);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mdr_q   <= '0;
      beat_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign eb_req  = req_q;
  assign eb_beat = beat_q;

  // ib is only driven while idle so a transfer never exposes partial data.
  assign ib = (ib_drive && (state_q == ST_IDLE)) ? mdr_q : {IB_W{1'bz}};
  // Write data is held from REQ entry until the acknowledge has been released.
  assign eb = (wr_q && (state_q == ST_REQ || state_q == ST_REL)) ? lane_wr : {EB_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mdr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdr_bridge
// Purpose  : Self-checking bench for mdr_bridge (IB_W=16, EB_W=8) with an
//            auto-acknowledging external device and a word-level MDR model.
//            Undriven bus bits are pulled high so a released bus reads all ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdr_bridge;

  localparam int IB_W  = 16;
  localparam int EB_W  = 8;
  localparam int TMO   = 15;
  localparam int BEATS = IB_W / EB_W;

  logic            clk = 1'b0;
  logic            reset;
  tri1 [IB_W-1:0]  ib;
  tri1 [EB_W-1:0]  eb;
  logic            ib_load, ib_drive, start_rd, start_wr, eb_ack;
  logic            busy, done, err, eb_req;
  logic            eb_beat;
  logic            tb_ib_oe, tb_eb_oe;
  logic [IB_W-1:0] tb_ib_val;
  logic [EB_W-1:0] tb_eb_val;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [IB_W-1:0] m_mdr;

  assign ib = tb_ib_oe ? tb_ib_val : {IB_W{1'bz}};
  assign eb = tb_eb_oe ? tb_eb_val : {EB_W{1'bz}};

  mdr_bridge #(.IB_W(IB_W), .EB_W(EB_W), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ib       (ib),
    .ib_load  (ib_load),
    .ib_drive (ib_drive),
    .start_rd (start_rd),
    .start_wr (start_wr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .eb       (eb),
    .eb_req   (eb_req),
    .eb_ack   (eb_ack),
    .eb_beat  (eb_beat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start_rd = 1'b0; start_wr = 1'b0; ib_load = 1'b0; ib_drive = 1'b0;
    tb_ib_oe = 1'b0; tb_eb_oe = 1'b0; eb_ack = 1'b0;
  endtask

  // Compare the MDR, seen through ib_drive, with the model (no clock edge used).
  task automatic check_mdr(input string tag);
    ib_drive = 1'b1;
    #1;
    check(tag, ib, m_mdr);
    ib_drive = 1'b0;
    #1;
  endtask

  task automatic load(input logic [IB_W-1:0] val);
    tb_ib_oe = 1'b1; tb_ib_val = val; ib_load = 1'b1;
    tick();
    tb_ib_oe = 1'b0; ib_load = 1'b0;
    m_mdr = val;
  endtask

  // One complete transfer with an immediately acknowledging device.
  task automatic xfer(input logic srd, input logic swr, input logic [IB_W-1:0] rdata,
                      input bit noise);
    int              beats_seen;
    int              dones;
    int              cyc;
    bit              is_rd;
    logic [IB_W-1:0] wdata;
    is_rd = srd;
    wdata = m_mdr;
    start_rd = srd; start_wr = swr;
    if (noise) begin
      tb_ib_oe = 1'b1; tb_ib_val = IB_W'($urandom); ib_load = 1'b1;
    end
    tick();
    start_rd = 1'b0; start_wr = 1'b0; ib_load = 1'b0; tb_ib_oe = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_after_start", err, 0);
    check("req_after_start", eb_req, 1);
    beats_seen = 0;
    dones = 0;
    cyc = 0;
    while (busy && cyc < 64) begin
      if (eb_req && !eb_ack) begin
        check("beat_index", eb_beat, beats_seen);
        if (is_rd) begin
          tb_eb_oe = 1'b1; tb_eb_val = rdata[beats_seen*EB_W +: EB_W];
        end else begin
          check("eb_write_lane", eb, wdata[beats_seen*EB_W +: EB_W]);
        end
        eb_ack = 1'b1;
        beats_seen++;
      end else if (!eb_req && eb_ack) begin
        if (!is_rd) check("eb_write_hold", eb, wdata[(beats_seen-1)*EB_W +: EB_W]);
        tb_eb_oe = 1'b0;
        eb_ack = 1'b0;
      end
      if (done) dones++;
      if (noise) begin
        start_rd = 1'($urandom); start_wr = 1'($urandom); ib_drive = 1'b1;
      end
      #1;
      if (noise) check("ib_z_while_busy", ib, {IB_W{1'b1}});
      tick();
      cyc++;
    end
    quiet();
    check("xfer_cycles", cyc, 2*BEATS + 1);
    check("beats_done", beats_seen, BEATS);
    check("done_pulses", dones, 1);
    check("idle_done_low", done, 0);
    check("eb_released", eb, {EB_W{1'b1}});
    if (is_rd) m_mdr = rdata;
    check_mdr("mdr_after_xfer");
  endtask

  initial begin
    int              cyc;
    int              reqc;
    int              op;
    logic [IB_W-1:0] v;
    quiet();
    tb_ib_val = '0; tb_eb_val = '0;
    m_mdr = '0;
    reset = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_req", eb_req, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset pulse while idle with a non-zero MDR.
    load(16'h5AA5);
    #2 reset = 1'b1;
    #1;
    m_mdr = '0;
    check("rst_idle_busy", busy, 0);
    check("rst_idle_done", done, 0);
    check("rst_idle_err", err, 0);
    check("rst_idle_req", eb_req, 0);
    check("rst_idle_ib_z", ib, {IB_W{1'b1}});
    check("rst_idle_eb_z", eb, {EB_W{1'b1}});
    check_mdr("rst_idle_mdr");
    reset = 1'b0;
    tick();

    // Internal load and drive.
    load(16'hA55A);
    check_mdr("load_a55a");
    check("load_eb_z", eb, {EB_W{1'b1}});

    // External read of two beats.
    xfer(1'b1, 1'b0, 16'h1234, 1'b0);

    // External write, then simultaneous starts resolve to a read.
    load(16'hBEEF);
    xfer(1'b0, 1'b1, 16'h0000, 1'b0);
    xfer(1'b1, 1'b1, 16'h5678, 1'b0);

    // Randomized mix of loads and transfers with busy-time noise.
    for (int k = 0; k < 10; k++) begin
      op = int'($urandom_range(0, 3));
      v  = IB_W'($urandom);
      case (op)
        0: begin load(v); check_mdr("rand_load"); end
        1: xfer(1'b1, 1'b0, v, bit'($urandom_range(0, 1)));
        2: xfer(1'b0, 1'b1, v, bit'($urandom_range(0, 1)));
        default: xfer(1'b1, 1'b1, v, bit'($urandom_range(0, 1)));
      endcase
    end

    // Device never acknowledges a read.
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    cyc = 0;
    reqc = 0;
`ifdef MDR_TIMEOUT_EN
    while (!done && cyc < 64) begin
      if (eb_req) reqc++;
      tick();
      cyc++;
    end
    check("tmo_req_cycles", reqc, TMO);
    check("tmo_done", done, 1);
    check("tmo_err", err, 1);
    check("tmo_req_low", eb_req, 0);
    tick();
    check("tmo_idle", busy, 0);
    check("tmo_err_sticky", err, 1);
    check_mdr("tmo_mdr_kept");
    xfer(1'b1, 1'b0, 16'hC3D4, 1'b0);
    check("tmo_err_cleared", err, 0);
`else
    while (cyc < 40) begin
      if (done) reqc++;
      tick();
      cyc++;
    end
    check("stall_busy", busy, 1);
    check("stall_err", err, 0);
    check("stall_req", eb_req, 1);
    check("stall_no_done", reqc, 0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_mdr = '0;
    tick();
    check("stall_recover", busy, 0);
`endif

    // Async reset while the second write beat is being requested.
    load(16'hC0DE);
    start_wr = 1'b1;
    tick();
    start_wr = 1'b0;
    eb_ack = 1'b1;
    tick();
    eb_ack = 1'b0;
    tick();
    check("beat1_index", eb_beat, 1);
    check("beat1_req", eb_req, 1);
    check("beat1_eb", eb, 8'hC0);
    reset = 1'b1;
    #1;
    m_mdr = '0;
    check("rst_beat1_busy", busy, 0);
    check("rst_beat1_req", eb_req, 0);
    check("rst_beat1_eb_z", eb, {EB_W{1'b1}});
    check("rst_beat1_beat", eb_beat, 0);
    check_mdr("rst_beat1_mdr");
    reset = 1'b0;
    reqc = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) reqc++;
    end
    check("rst_beat1_no_done", reqc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
